// File: rtl/tinyalu_initiator.sv
// Command-side master for the tinyalu start/done handshake: takes one command at a time,
// runs it on the ALU (or answers locally), and returns the captured result on a response stream.
module tinyalu_initiator #(
    parameter int TIMEOUT_CYC = 15,
    parameter int DRAIN_CYC   = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_NOP     = 2'd0,
        CLS_ALU     = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_t;

    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC);

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  b_reg, b_next;
    logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [3:0]  drain_cnt_reg, drain_cnt_next;
    logic [15:0] rsp_result_reg, rsp_result_next;
    logic [2:0]  rsp_op_reg, rsp_op_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    op_class_t   cmd_class;
    logic [3:0]  drain_dec;

    always_comb begin
        cmd_class = CLS_ILLEGAL;
        if (cmd_op == 3'd0) begin
            cmd_class = CLS_NOP;
        end else if (cmd_op <= 3'd4) begin
            cmd_class = CLS_ALU;
        end
    end

    // Drain counter only ever counts down to zero and stays there.
    assign drain_dec = (drain_cnt_reg == 4'd0) ? 4'd0 : drain_cnt_reg - 4'd1;

    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        a_next           = a_reg;
        b_next           = b_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        drain_cnt_next   = drain_cnt_reg;
        rsp_result_next  = rsp_result_reg;
        rsp_op_next      = rsp_op_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next = cmd_op;
                    a_next  = cmd_a;
                    b_next  = cmd_b;
                    if (cmd_class == CLS_ALU) begin
                        state_next   = RUN;
                        tmo_cnt_next = 8'd0;
                    end else begin
                        // No-op and illegal opcodes are answered without touching the ALU.
                        state_next       = RESP;
                        rsp_result_next  = 16'd0;
                        rsp_op_next      = cmd_op;
                        rsp_err_next     = (cmd_class == CLS_ILLEGAL);
                        rsp_timeout_next = 1'b0;
                        drain_cnt_next   = 4'd0;
                    end
                end
            end

            RUN: begin
                if (alu_done) begin
                    state_next       = RESP;
                    rsp_result_next  = alu_result;
                    rsp_op_next      = op_reg;
                    rsp_err_next     = 1'b0;
                    rsp_timeout_next = 1'b0;
                    drain_cnt_next   = DRAIN_LOAD;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next       = RESP;
                    rsp_result_next  = 16'd0;
                    rsp_op_next      = op_reg;
                    rsp_err_next     = 1'b0;
                    rsp_timeout_next = 1'b1;
                    drain_cnt_next   = DRAIN_LOAD;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
            end

            RESP: begin
                drain_cnt_next = drain_dec;
                if (rsp_ready) begin
                    state_next = (drain_cnt_reg == 4'd0) ? IDLE : DRAIN;
                end
            end

            DRAIN: begin
                // Late alu_done pulses land here and are simply ignored.
                drain_cnt_next = drain_dec;
                if (drain_cnt_reg <= 4'd1) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            op_reg          <= 3'd0;
            a_reg           <= 8'd0;
            b_reg           <= 8'd0;
            tmo_cnt_reg     <= 8'd0;
            drain_cnt_reg   <= 4'd0;
            rsp_result_reg  <= 16'd0;
            rsp_op_reg      <= 3'd0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_reg          <= op_next;
            a_reg           <= a_next;
            b_reg           <= b_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            drain_cnt_reg   <= drain_cnt_next;
            rsp_result_reg  <= rsp_result_next;
            rsp_op_reg      <= rsp_op_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    // Handshake outputs are pure decodes of the registered state, so they never glitch.
    assign cmd_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign alu_start   = (state_reg == RUN);
    assign rsp_valid   = (state_reg == RESP);
    assign alu_op      = op_reg;
    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_op      = rsp_op_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_tinyalu_initiator.sv
// Bench for tinyalu_initiator: emulated ALU, response-queue model with a per-cycle
// compare process, and directed timing checks with hand-computed values.
module tb_tinyalu_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;

    always #5 clk = ~clk;

    tinyalu_initiator #(.TIMEOUT_CYC(15), .DRAIN_CYC(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t exp_q[$];
    bit   mon_en = 0;
    bit   alu_dead = 0;
    bit   extra_pending = 0;

    // What the response must be, straight from the opcode table.
    function automatic rsp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input bit dead);
        rsp_t r;
        r.op = op; r.a = a; r.b = b; r.err = (op > 3'd4); r.tmo = 1'b0; r.res = 16'h0000;
        case (op)
            3'd1: r.res = 16'(a) + 16'(b);
            3'd2: r.res = {8'h00, a & b};
            3'd3: r.res = {8'h00, a ^ b};
            3'd4: r.res = 16'(a) * 16'(b);
            default: r.res = 16'h0000;
        endcase
        if (dead && op >= 3'd1 && op <= 3'd4) begin
            r.res = 16'h0000;
            r.tmo = 1'b1;
        end
        return r;
    endfunction

    // Emulated ALU: add/and/xor finish one cycle after start rises, mul three.
    logic start_seen = 1'b0;
    int   alu_cnt = 0;
    always @(negedge clk) start_seen = alu_start;
    always @(posedge clk) begin
        bit normal;
        #1;
        if (start_seen) alu_cnt++; else alu_cnt = 0;
        normal = !alu_dead && start_seen && (alu_cnt == ((alu_op == 3'd4) ? 3 : 1));
        if (normal) begin
            alu_done = 1'b1;
            case (alu_op)
                3'd1: alu_result = 16'(alu_a) + 16'(alu_b);
                3'd2: alu_result = {8'h00, alu_a & alu_b};
                3'd3: alu_result = {8'h00, alu_a ^ alu_b};
                default: alu_result = 16'(alu_a) * 16'(alu_b);
            endcase
        end else if (extra_pending) begin
            extra_pending = 0;
            alu_done   = 1'b1;
            alu_result = 16'hBEEF;
        end else begin
            alu_done   = 1'b0;
            alu_result = 16'hDEAD;
        end
    end

    // Compare process: every cycle, outputs against the outstanding-command queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmd_ready_eq_not_busy", cmd_ready, !busy);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp_valid", rsp_valid, 1'b0);
                end else begin
                    chk("mon_rsp_result", rsp_result, exp_q[0].res);
                    chk("mon_rsp_op", rsp_op, exp_q[0].op);
                    chk("mon_rsp_err", rsp_err, exp_q[0].err);
                    chk("mon_rsp_timeout", rsp_timeout, exp_q[0].tmo);
                    chk("mon_start_low_in_rsp", alu_start, 1'b0);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (alu_start) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_alu_start", alu_start, 1'b0);
                end else begin
                    chk("mon_alu_op", alu_op, exp_q[0].op);
                    chk("mon_alu_a", alu_a, exp_q[0].a);
                    chk("mon_alu_b", alu_b, exp_q[0].b);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a command; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit acc = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = cmd_ready;
            sync();
        end
        if (!acc) chk("cmd_accept_bound", cmd_ready, 1'b1);
        else exp_q.push_back(model(op, a, b, alu_dead));
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    endtask

    task automatic count_start(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (alu_start) cnt++;
            else break;
        end
    endtask

    task automatic cycles_to_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (cmd_ready) break;
        end
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        chk(name, rsp_valid, 1'b1);
    endtask

    initial begin
        int n;
        rsp_t m;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00; rsp_ready = 1'b1;

        // Pin the model with hand-computed values.
        m = model(3'd1, 8'h12, 8'h34, 0); chk("model_add", m.res, 16'h0046);
        m = model(3'd4, 8'hFF, 8'hFF, 0); chk("model_mul", m.res, 16'hFE01);
        m = model(3'd3, 8'hF0, 8'h3C, 0); chk("model_xor", m.res, 16'h00CC);
        m = model(3'd6, 8'h11, 8'h22, 0); chk("model_illegal_err", m.err, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_start", alu_start, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_abop", {alu_op, alu_a, alu_b}, 19'h0);
        chk("rst_rsp_fields", {rsp_result, rsp_op, rsp_err, rsp_timeout}, 21'h0);
        sync();
        reset_n = 1'b1;
        mon_en = 1;

        // add 0x12 + 0x34
        issue(3'd1, 8'h12, 8'h34);
        @(negedge clk);
        chk("add_start_t1", alu_start, 1'b1);
        chk("add_alu_a", alu_a, 8'h12);
        chk("add_alu_b", alu_b, 8'h34);
        chk("add_busy", busy, 1'b1);
        chk("add_cmd_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        chk("add_start_t2", alu_start, 1'b1);
        chk("add_no_rsp_t2", rsp_valid, 1'b0);
        @(negedge clk);
        chk("add_start_drop", alu_start, 1'b0);
        chk("add_rsp_valid_t3", rsp_valid, 1'b1);
        chk("add_rsp_result", rsp_result, 16'h0046);
        chk("add_rsp_op", rsp_op, 3'd1);
        chk("add_rsp_flags", {rsp_err, rsp_timeout}, 2'b00);
        cycles_to_idle(n);
        chk("add_drain_cycles", n, 3);
        sync();

        // mul 0xFF * 0xFF, then a stray done during drain
        issue(3'd4, 8'hFF, 8'hFF);
        count_start(n);
        chk("mul_start_cycles", n, 4);
        chk("mul_rsp_valid", rsp_valid, 1'b1);
        chk("mul_rsp_result", rsp_result, 16'hFE01);
        sync();
        extra_pending = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mul_drain_no_rsp", rsp_valid, 1'b0);
        end
        chk("mul_idle_after_drain", cmd_ready, 1'b1);
        sync();

        // no_op then illegal op 6, back to back
        issue(3'd0, 8'h55, 8'hAA);
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_a = 8'h11; cmd_b = 8'h22;
        @(negedge clk);
        chk("nop_rsp_valid", rsp_valid, 1'b1);
        chk("nop_rsp_result", rsp_result, 16'h0000);
        chk("nop_rsp_err", rsp_err, 1'b0);
        chk("nop_no_start", alu_start, 1'b0);
        sync();
        @(negedge clk);
        chk("nop_idle_next", cmd_ready, 1'b1);
        sync();
        exp_q.push_back(model(3'd6, 8'h11, 8'h22, 0));
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ill_rsp_valid", rsp_valid, 1'b1);
        chk("ill_rsp_err", rsp_err, 1'b1);
        chk("ill_rsp_op", rsp_op, 3'd6);
        chk("ill_rsp_result", rsp_result, 16'h0000);
        chk("ill_no_start", alu_start, 1'b0);
        sync();
        @(negedge clk);
        chk("ill_idle_next", cmd_ready, 1'b1);
        sync();

        // timeout with a dead ALU
        alu_dead = 1;
        issue(3'd1, 8'h01, 8'h02);
        count_start(n);
        chk("tmo_start_cycles", n, 15);
        chk("tmo_rsp_valid", rsp_valid, 1'b1);
        chk("tmo_rsp_timeout", rsp_timeout, 1'b1);
        chk("tmo_rsp_result", rsp_result, 16'h0000);
        cycles_to_idle(n);
        chk("tmo_drain_cycles", n, 3);
        alu_dead = 0;
        sync();

        // xor with response back-pressure
        rsp_ready = 1'b0;
        issue(3'd3, 8'hF0, 8'h3C);
        wait_rsp("xor_rsp_bound");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("xor_hold_valid", rsp_valid, 1'b1);
            chk("xor_hold_result", rsp_result, 16'h00CC);
            chk("xor_hold_cmd_ready", cmd_ready, 1'b0);
        end
        sync();
        rsp_ready = 1'b1;
        sync();
        @(negedge clk);
        chk("xor_idle_after_hs", cmd_ready, 1'b1);
        chk("xor_valid_drop", rsp_valid, 1'b0);
        sync();

        // reset in the middle of a mul
        issue(3'd4, 8'h03, 8'h05);
        @(negedge clk);
        chk("rstmid_start", alu_start, 1'b1);
        sync();
        reset_n = 1'b0;
        sync();
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rstmid_start_low", alu_start, 1'b0);
        chk("rstmid_rsp_valid", rsp_valid, 1'b0);
        chk("rstmid_cmd_ready", cmd_ready, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_alu_abop", {alu_op, alu_a, alu_b}, 19'h0);
        chk("rstmid_rsp_fields", {rsp_result, rsp_op, rsp_err, rsp_timeout}, 21'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_no_rsp", rsp_valid, 1'b0);
        end
        sync();
        issue(3'd1, 8'h07, 8'h08);
        wait_rsp("post_rst_rsp_bound");
        chk("post_rst_add_result", rsp_result, 16'h000F);
        cycles_to_idle(n);
        chk("post_rst_idle", cmd_ready, 1'b1);
        chk("all_rsp_consumed", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tinyalu_initiator.md
Name: tinyalu_initiator

Overview:
Command-side master for the tinyalu handshake (start/op/A/B in, done/result out). It accepts operation requests on a valid/ready command stream and drives one ALU transaction at a time. It captures the ALU result and returns it on a valid/ready response stream. It sits between the testbench/host sequencer and the ALU, owning start timing, result capture, post-op drain and timeout.

Parameters:
TIMEOUT_CYC, 15, max cycles alu_start may be held without alu_done before the op is aborted (4..255)
DRAIN_CYC, 3, minimum cycles alu_start stays low after each ALU op; alu_done is ignored during this window (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  3  0=no_op 1=add 2=and 3=xor 4=mul, 5-7 illegal
cmd_a  in  8  operand A
cmd_b  in  8  operand B
alu_start  out  1  ALU start
alu_op  out  3  ALU opcode, registered
alu_a  out  8  ALU operand A, registered
alu_b  out  8  ALU operand B, registered
alu_done  in  1  ALU completion
alu_result  in  16  ALU result, valid when alu_done=1
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_result  out  16  captured result (0 on no_op/illegal/timeout)
rsp_op  out  3  opcode of the completed command
rsp_err  out  1  1 = illegal opcode
rsp_timeout  out  1  1 = aborted by timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE; alu_start=0, alu_op/alu_a/alu_b=0, rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0, rsp_timeout=0, busy=0, counters=0. Reset mid-operation aborts immediately: start drops next edge, no response is produced, the pending command is lost.
- cmd_ready = (state==IDLE); combinational from state only, never from cmd_valid.
- States: IDLE, RUN, RESP, DRAIN.
- IDLE: on cmd handshake at edge T, operands/op/op-class are registered.
  - op 1-4: go to RUN; alu_start=1 from T+1 with alu_op/a/b stable; timeout counter cleared.
  - op 0: go to RESP with rsp_result=0, err=0, timeout=0; alu_start never asserted; rsp_valid visible at T+1.
  - op 5-7: same as op 0 but rsp_err=1.
- RUN: alu_start held 1, operands held stable. alu_done sampled each edge.
  - Edge with alu_done=1: rsp_result<=alu_result, rsp_op<=op; alu_start=0 and rsp_valid=1 from next cycle; drain counter<=DRAIN_CYC; go to RESP.
  - Otherwise counter increments. If TIMEOUT_CYC edges pass without done, abort: rsp_result=0, rsp_timeout=1, drain loaded; go to RESP.
  - Add/and/xor complete with done sampled 1 cycle after start rises. Mul completes 3 cycles after start rises. The first done sampled wins.
- RESP: rsp_valid=1, rsp_* stable until handshake. Drain counter decrements each cycle (saturates at 0). alu_done is ignored.
  - Handshake with drain==0: go to IDLE.
  - Handshake with drain>0: go to DRAIN.
  - rsp_valid deasserts the cycle after the handshake.
- DRAIN: alu_start=0; counter decrements; at 0 go to IDLE. Any alu_done here is discarded; no spurious response is generated.
- Responses for local ops (0, 5-7) load drain=0.
- Exactly one response per accepted command; responses issue in command order; at most one outstanding.

Test Plan:
- add A=0x12 B=0x34 accepted at T -> alu_start 1 at T+1..T+2, rsp_valid at T+3, rsp_result=0x0046, rsp_op=1, err=0, timeout=0; next cmd_ready no earlier than 3 drain cycles after done.
- mul A=0xFF B=0xFF -> done 3 cycles after start, rsp_result=0xFE01. A trailing extra alu_done pulse during DRAIN produces no second response.
- no_op then op=6 back-to-back -> no alu_start; two responses with result 0, rsp_err=0 then 1, each one cycle after accept.
- alu_done tied 0, add issued -> after 15 RUN cycles start drops, rsp_timeout=1, rsp_result=0, then IDLE after drain.
- xor A=0xF0 B=0x3C with rsp_ready low 10 cycles -> rsp_valid/rsp_result=0x00CC held stable, cmd_ready=0 throughout, IDLE after handshake.
- reset_n low for one edge during RUN of a mul -> all outputs at reset values next cycle, no response; next add completes normally.
